pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Frame-level controller for bit-serial pattern detection. It accepts parallel data words over a valid/ready handshake and serializes each word MSB-first through an internal, runtime-configurable pattern matcher. It counts matches over a multi-word frame and reports the count on an output handshake. It sits between a word-oriented producer and status logic that needs match statistics, and it owns sequencing, configuration and result reporting for the serial detector.

## Interface
- DW, 16, input word width (bits serialized per word)
- PMAX, 8, maximum pattern length
- CW, 8, match counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_pat  in  PMAX  pattern; bit 0 = most recent serial bit
- cfg_len  in  4  pattern length; 0 treated as 1, >PMAX clamped to PMAX
- cfg_win  in  3  hit hold window in bits; 0 treated as 1
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_data  in  DW  input word
- in_last  in  1  word is last of frame (sampled with in_data)
- bit_valid  out  1  serial bit emitted this cycle
- bit_val  out  1  emitted bit value
- hit  out  1  registered: a match ended within the last cfg_win emitted bits
- out_valid  out  1  frame result valid
- out_count  out  CW  matches in frame, saturating
- out_ready  in  1  result consumer ready
- busy  out  1  frame in progress (first word accepted, result not yet taken)

## Operation
- States: IDLE, SHIFT, REPORT. Reset -> IDLE; all outputs 0; config = pattern 0, len 1, win 1.
- IDLE: in_ready=1. On in_valid&in_ready: load shifter with in_data, latch in_last, bit counter=DW, set busy, -> SHIFT.
- SHIFT: in_ready=0; each cycle bit_valid=1 and bit_val=shifter MSB; shifter shifts left; history register (PMAX bits) shifts the bit in at bit 0; fill counter increments, saturating at PMAX.
- Match on a bit: fill (including the current bit) >= len, and history[len-1:0] after the shift == cfg_pat[len-1:0]. Overlapping matches count.
- On each match: counter += 1, saturating at 2^CW-1; hit age reloads to win.
- On a non-matching bit: age decrements toward 0. hit = (age>0), updated only on emitted bits and held otherwise.
- After the DW-th bit: -> REPORT if the latched last flag is set, else -> IDLE. History, fill, age and count persist across words of a frame.
- REPORT: out_valid=1 with out_count stable until out_ready. On out_valid&out_ready: clear count, history, fill, age and hit; busy=0; -> IDLE.
- cfg_we takes effect only in IDLE with busy=0. It is ignored otherwise, with no queuing.
- rst in any state returns to IDLE immediately. An in-flight word and any pending result are discarded.

## Timing
- Word accepted at edge t: bits appear in cycles t+1 .. t+DW, MSB first.
- Earliest next word acceptance: cycle t+DW+1, so max throughput is 1 word per DW+1 cycles.
- hit for bit k is visible in the cycle after bit k's bit_valid cycle.
- out_valid rises in the cycle after the last bit of a last word. Earliest next frame acceptance is the cycle after the out_valid&out_ready handshake.
- cfg_we and in_valid in the same IDLE cycle with busy=0: config is written and the word is accepted; the new config applies to that word.
- out_count is captured after the final bit, so a match on the final bit is included.

## Test plan
- cfg pat=3'b101, len=3, win=4; one word 0x5354 with last=1 -> hit sequence after bits 0..15 = 0001111001111111; out_valid with out_count=4.
- Two-word frame 0x0001 (last=0) then 0x4000 (last=1), pat 101 -> match straddles the word boundary (bits 15,16,17); out_count=1.
- pat=1'b1, len=1; 16 words of 0xFFFF, the last flagged -> out_count saturates at 255, not wrap to 0.
- Hold out_ready=0 for 10 cycles in REPORT -> out_valid and out_count stay stable, in_ready=0, and a cfg_we during this time is ignored.
- Assert rst mid-SHIFT at bit 7 -> next cycle bit_valid=0, hit=0, busy=0, in_ready=1; the following frame counts from 0.
- cfg_len=0, cfg_win=0, cfg_pat=0 on word 0x0000 last=1 -> treated as len 1, win 1; out_count=16; hit asserted for one bit per match (continuous 1 from cycle after bit 0).

Source files
------------

// File: rtl/pattern_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_scan_ctrl_if                                            |
// | Brief    : word-input and result-output handshakes of pattern_scan_ctrl    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pattern_scan_ctrl_if #(
  parameter int DW = 16,
  parameter int CW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_scan_ctrl                                               |
// | Brief    : serializes words MSB-first through a configurable pattern       |
// |            matcher and reports saturating per-frame match counts           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pattern_scan_ctrl #(
  parameter int DW   = 16,
  parameter int PMAX = 8,
  parameter int CW   = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            cfg_we,
  input  wire logic [PMAX-1:0] cfg_pat,
  input  wire logic [3:0]      cfg_len,
  input  wire logic [2:0]      cfg_win,
  pattern_scan_ctrl_if.slave   io,
  output logic                 bit_valid,
  output logic                 bit_val,
  output logic                 hit,
  output logic                 busy
);

  localparam int c_LW = $clog2(PMAX + 1);
  localparam int c_BW = $clog2(DW + 1);
  localparam logic [3:0]      c_PMAX4  = 4'(PMAX);
  localparam logic [c_LW-1:0] c_PMAX_L = c_LW'(PMAX);
  localparam logic [c_BW-1:0] c_DW_B   = c_BW'(DW);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nx;
  logic [DW-1:0]   r_shift;
  logic            r_last;
  logic [c_BW-1:0] r_bitcnt;
  logic            r_busy;
  logic [PMAX-1:0] r_hist;
  logic [c_LW-1:0] r_fill;
  logic [2:0]      r_age;
  logic            r_hit;
  logic [CW-1:0]   r_count;
  logic [PMAX-1:0] r_pat;
  logic [c_LW-1:0] r_len;
  logic [2:0]      r_win;

  logic            w_in_ready;
  logic            w_bit_valid;
  logic            w_out_valid;
  logic            w_cfg_ok;
  logic [3:0]      w_len_n;
  logic [2:0]      w_win_n;
  logic [PMAX-1:0] w_hist_nx;
  logic [c_LW-1:0] w_fill_nx;
  logic [PMAX-1:0] w_mask;
  logic            w_match;
  logic [2:0]      w_age_nx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (io.in_valid) w_state_nx = S_SHIFT;
      S_SHIFT:  if (r_bitcnt == c_BW'(1)) w_state_nx = r_last ? S_REPORT : S_IDLE;
      S_REPORT: if (io.out_ready) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_bit_valid = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:   w_in_ready  = 1'b1;
      S_SHIFT:  w_bit_valid = 1'b1;
      S_REPORT: w_out_valid = 1'b1;
      default:  w_in_ready  = 1'b0;
    endcase
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = w_out_valid;
  assign io.out_count = r_count;
  assign bit_valid    = w_bit_valid;
  assign bit_val      = r_shift[DW-1];
  assign hit          = r_hit;
  assign busy         = r_busy;

  // Config only lands between frames, never while one is in progress.
  assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && !r_busy;
  assign w_len_n  = (cfg_len == 4'd0) ? 4'd1 : ((cfg_len > c_PMAX4) ? c_PMAX4 : cfg_len);
  assign w_win_n  = (cfg_win == 3'd0) ? 3'd1 : cfg_win;

  assign w_hist_nx = {r_hist[PMAX-2:0], r_shift[DW-1]};
  assign w_fill_nx = (r_fill == c_PMAX_L) ? r_fill : r_fill + c_LW'(1);
  assign w_mask    = ~({PMAX{1'b1}} << r_len);
  assign w_match   = (w_fill_nx >= r_len) && (((w_hist_nx ^ r_pat) & w_mask) == '0);
  assign w_age_nx  = w_match ? r_win : ((r_age != 3'd0) ? r_age - 3'd1 : 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_last   <= 1'b0;
      r_bitcnt <= '0;
      r_busy   <= 1'b0;
      r_hist   <= '0;
      r_fill   <= '0;
      r_age    <= 3'd0;
      r_hit    <= 1'b0;
      r_count  <= '0;
      r_pat    <= '0;
      r_len    <= c_LW'(1);
      r_win    <= 3'd1;
    end else begin
      if (w_cfg_ok) begin
        r_pat <= cfg_pat;
        r_len <= c_LW'(w_len_n);
        r_win <= w_win_n;
      end
      case (r_state)
        S_IDLE: begin
          if (io.in_valid) begin
            r_shift  <= io.in_data;
            r_last   <= io.in_last;
            r_bitcnt <= c_DW_B;
            r_busy   <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_shift  <= {r_shift[DW-2:0], 1'b0};
          r_bitcnt <= r_bitcnt - c_BW'(1);
          r_hist   <= w_hist_nx;
          r_fill   <= w_fill_nx;
          r_age    <= w_age_nx;
          r_hit    <= (w_age_nx != 3'd0);
          if (w_match && (r_count != '1)) r_count <= r_count + CW'(1);
        end
        S_REPORT: begin
          if (io.out_ready) begin
            r_count <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_age   <= 3'd0;
            r_hit   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_busy <= r_busy;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pattern_scan_ctrl                                            |
// | Brief    : self-checking bench for pattern_scan_ctrl                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pattern_scan_ctrl;
  localparam int DW = 16, PMAX = 8, CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [PMAX-1:0] cfg_pat = '0;
  logic [3:0]      cfg_len = '0;
  logic [2:0]      cfg_win = '0;
  logic            bit_valid, bit_val, hit, busy;

  pattern_scan_ctrl_if #(.DW(DW), .CW(CW)) io ();

  pattern_scan_ctrl #(.DW(DW), .PMAX(PMAX), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_win(cfg_win), .io(io), .bit_valid(bit_valid), .bit_val(bit_val),
    .hit(hit), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  // Reference model: whole frame kept as a bit list plus match positions.
  int   m_pat, m_len, m_win;
  logic m_bits[$];
  int   m_match[$];
  logic m_hit, m_busy;
  logic [DW-1:0] hseq;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_cfg(input logic [PMAX-1:0] p, input logic [3:0] l, input logic [2:0] w);
    m_pat = int'(p);
    m_len = (l == 0) ? 1 : ((int'(l) > PMAX) ? PMAX : int'(l));
    m_win = (w == 0) ? 1 : int'(w);
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_match.delete();
    m_hit = 1'b0;
  endtask

  task automatic model_bit(input logic b);
    int  idx;
    bit  ok;
    m_bits.push_back(b);
    idx = m_bits.size() - 1;
    if (m_bits.size() >= m_len) begin
      ok = 1'b1;
      for (int j = 0; j < m_len; j++)
        if (m_bits[idx-j] !== m_pat[j]) ok = 1'b0;
      if (ok) m_match.push_back(idx);
    end
    m_hit = 1'b0;
    foreach (m_match[i])
      if (idx - m_match[i] < m_win) m_hit = 1'b1;
  endtask

  function automatic int m_count();
    return (m_match.size() > 255) ? 255 : m_match.size();
  endfunction

  // Entered and left on a negedge; DUT must be idle on entry.
  task automatic do_word(input logic [DW-1:0] d, input logic last, input logic wcfg,
                         input logic [PMAX-1:0] p, input logic [3:0] l, input logic [2:0] w);
    chk("in_ready_idle", io.in_ready, 1);
    io.in_valid = 1'b1; io.in_data = d; io.in_last = last;
    cfg_we = wcfg; cfg_pat = p; cfg_len = l; cfg_win = w;
    if (wcfg && !m_busy) model_cfg(p, l, w);
    m_busy = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < DW; k++) begin
      chk("bit_valid", bit_valid, 1);
      chk("bit_val", bit_val, d[DW-1-k]);
      chk("hit", hit, m_hit);
      chk("in_ready_shift", io.in_ready, 0);
      if (k > 0) hseq[DW-k] = hit;
      model_bit(d[DW-1-k]);
      @(negedge clk);
    end
    hseq[0] = hit;
    chk("hit_last", hit, m_hit);
    chk("bit_valid_end", bit_valid, 0);
    chk("busy", busy, 1);
    if (last) begin
      chk("out_valid", io.out_valid, 1);
      chk("out_count", io.out_count, m_count());
    end else begin
      chk("in_ready_next", io.in_ready, 1);
    end
  endtask

  task automatic do_report(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("out_valid_hold", io.out_valid, 1);
      chk("out_count_hold", io.out_count, m_count());
      chk("in_ready_rep", io.in_ready, 0);
      cfg_we = 1'b1; cfg_pat = PMAX'($urandom); cfg_len = 4'($urandom); cfg_win = 3'($urandom);
      @(negedge clk);
    end
    cfg_we = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("out_valid_done", io.out_valid, 0);
    chk("busy_done", busy, 0);
    chk("hit_done", hit, 0);
    chk("in_ready_done", io.in_ready, 1);
    model_clear();
    m_busy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    io.in_valid = 1'b0; io.in_data = '0; io.in_last = 1'b0; io.out_ready = 1'b0;
    model_cfg('0, 4'd1, 3'd1); model_clear(); m_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_count", io.out_count, 0);

    // Single word, known hit sequence.
    do_word(16'h5354, 1'b1, 1'b1, 8'b101, 4'd3, 3'd4);
    chk("t1_hitseq", hseq, 16'b0001111001111111);
    chk("t1_count", io.out_count, 4);
    do_report(0);

    // Match straddling a word boundary.
    do_word(16'h0001, 1'b0, 1'b1, 8'b101, 4'd3, 3'd4);
    do_word(16'h4000, 1'b1, 1'b0, '0, 4'd0, 3'd0);
    chk("t2_count", io.out_count, 1);
    do_report(0);

    // Saturation, then a held report with ignored config writes.
    for (int i = 0; i < 16; i++)
      do_word(16'hFFFF, (i == 15), (i == 0), 8'b1, 4'd1, 3'd1);
    chk("t3_count", io.out_count, 255);
    do_report(10);

    // Degenerate config values.
    do_word(16'h0000, 1'b1, 1'b1, 8'h00, 4'd0, 3'd0);
    chk("t5_count", io.out_count, 16);
    chk("t5_hitseq", hseq, 16'hFFFF);
    do_report(1);

    // Reset in the middle of a word.
    chk("t4_in_ready", io.in_ready, 1);
    io.in_valid = 1'b1; io.in_data = 16'h5354; io.in_last = 1'b1;
    cfg_we = 1'b1; cfg_pat = 8'b101; cfg_len = 4'd3; cfg_win = 3'd4;
    @(negedge clk);
    io.in_valid = 1'b0; cfg_we = 1'b0;
    repeat (7) @(negedge clk);
    chk("t4_bit7_valid", bit_valid, 1);
    chk("t4_hit_before", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_bit_valid", bit_valid, 0);
    chk("t4_hit", hit, 0);
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", io.in_ready, 1);
    model_cfg('0, 4'd1, 3'd1); model_clear(); m_busy = 1'b0;
    do_word(16'h5354, 1'b1, 1'b1, 8'b101, 4'd3, 3'd4);
    chk("t4_count", io.out_count, 4);
    do_report(0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        logic [DW-1:0] d;
        d = (($urandom_range(0, 3)) == 0) ? DW'($urandom & $urandom) : DW'($urandom);
        if (w > 0 && $urandom_range(0, 2) == 0) begin
          cfg_we = 1'b1; cfg_pat = PMAX'($urandom); cfg_len = 4'($urandom); cfg_win = 3'($urandom);
          chk("gap_busy", busy, 1);
          @(negedge clk);
          cfg_we = 1'b0;
        end
        do_word(d, (w == nw - 1), (w == 0) && ($urandom_range(0, 3) != 0),
                PMAX'($urandom), 4'($urandom_range(0, 15)), 3'($urandom));
      end
      do_report($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
